// File: rtl/bcd_seg7_scan.sv
// Latches a 4-digit BCD value and time-multiplexes it onto a common-anode 7-segment display.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module bcd_seg7_scan #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    digit_reg;   // 3 = thousands ... 0 = ones, so it also indexes an[]
  logic [15:0]   pend_reg;
  logic [15:0]   disp_reg;
  logic [3:0]    pend_dp_reg;
  logic [3:0]    disp_dp_reg;
  logic          pend_flag_reg;

  logic [15:0] in_value;
  logic        slot_end;
  logic        frame_end;
  logic        on_phase;
  logic [3:0]  cur_digit;
  logic [3:0]  suppress;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign in_value  = {thousands, hundreds, tens, ones};
  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (digit_reg == 2'd0);
  assign on_phase  = (cnt_reg >= BLANK_END);
  assign cur_digit = disp_reg[{digit_reg, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      digit_reg <= 2'd3;
    end else if (slot_end) begin
      cnt_reg   <= '0;
      digit_reg <= digit_reg - 2'd1;
    end else begin
      cnt_reg   <= cnt_reg + CW'(1);
    end
  end

  // Display only changes on the frame boundary; a strobe on that very edge bypasses pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= '0;
      pend_dp_reg   <= '0;
      pend_flag_reg <= 1'b0;
      disp_reg      <= '0;
      disp_dp_reg   <= '0;
    end else begin
      if (in_valid) begin
        pend_reg    <= in_value;
        pend_dp_reg <= dp_in;
      end
      if (frame_end) begin
        pend_flag_reg <= 1'b0;
        if (in_valid) begin
          disp_reg    <= in_value;
          disp_dp_reg <= dp_in;
        end else if (pend_flag_reg) begin
          disp_reg    <= pend_reg;
          disp_dp_reg <= pend_dp_reg;
        end
      end else if (in_valid) begin
        pend_flag_reg <= 1'b1;
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] digit_zero;
  for (genvar gi = 0; gi < 4; gi++) begin : g_zero
    assign digit_zero[gi] = (disp_reg[gi*4 +: 4] == 4'd0);
  end
  // A digit is blanked only while every digit to its left is also zero; ones always shows.
  assign suppress = {digit_zero[3],
                     digit_zero[3] & digit_zero[2],
                     digit_zero[3] & digit_zero[2] & digit_zero[1],
                     1'b0};
`else
  assign suppress = 4'd0;
`endif

  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (on_phase && !suppress[digit_reg]) begin
      an_next[digit_reg] = 1'b0;
      seg_next           = decode(cur_digit);
      dp_next            = ~disp_dp_reg[digit_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Bench for bcd_seg7_scan (PRESCALE=8, BLANK_CYCLES=2): table vectors, hand sequences,
// and random strobes against a frame-position reference model. Honours SEG7_LEADING_ZERO_BLANK_EN.
module tb_bcd_seg7_scan;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk, rst_n, in_valid;
  logic [3:0] thousands, hundreds, tens, ones, dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;

  bcd_seg7_scan #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
    .dp_in(dp_in), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int checks = 0;
  int errors = 0;
  int e = 0;          // edges since reset release
  int last_pos = -1;  // frame position (cnt state) consumed by the latest edge

  logic [3:0] m_disp [4];
  logic [3:0] m_pend [4];
  logic [3:0] m_disp_dp, m_pend_dp;
  bit         m_pflag;
  logic [6:0] dec_tab [16];

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        on_bnd;
    logic [27:0] segs;   // {thousands, hundreds, tens, ones}
    logic [3:0]  lit;
    logic [3:0]  dpo;
  } vec_t;
  localparam int NV = 8;
  vec_t vecs [NV];

  function automatic logic [6:0] ref_dec(input logic [3:0] v);
    return dec_tab[v];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      m_disp[j] = 4'd0;
      m_pend[j] = 4'd0;
    end
    m_disp_dp = 4'd0;
    m_pend_dp = 4'd0;
    m_pflag   = 1'b0;
    e         = 0;
    last_pos  = -1;
  endtask

  task automatic step(input logic v, input logic [15:0] val, input logic [3:0] dpi);
    int pos, d, ph;
    logic sup;
    logic [3:0] ea;
    logic [6:0] es;
    logic edp, eft;
    in_valid  = v;
    thousands = val[15:12];
    hundreds  = val[11:8];
    tens      = val[7:4];
    ones      = val[3:0];
    dp_in     = dpi;
    @(posedge clk);
    pos = e % FRAME;
    d   = 3 - pos / P;
    ph  = pos % P;
    sup = 1'b0;
    if (LZB && d != 0) begin
      sup = 1'b1;
      for (int j = 3; j >= d; j--) if (m_disp[j] != 4'd0) sup = 1'b0;
    end
    ea = 4'hF; es = 7'h7F; edp = 1'b1;
    if (ph >= B && !sup) begin
      ea[d] = 1'b0;
      es    = ref_dec(m_disp[d]);
      edp   = ~m_disp_dp[d];
    end
    eft = (pos == FRAME - 1);
    if (pos == FRAME - 1) begin
      if (v) begin
        for (int j = 0; j < 4; j++) m_disp[j] = val[j*4 +: 4];
        m_disp_dp = dpi;
        m_pflag   = 1'b0;
      end else if (m_pflag) begin
        for (int j = 0; j < 4; j++) m_disp[j] = m_pend[j];
        m_disp_dp = m_pend_dp;
        m_pflag   = 1'b0;
      end
    end else if (v) begin
      for (int j = 0; j < 4; j++) m_pend[j] = val[j*4 +: 4];
      m_pend_dp = dpi;
      m_pflag   = 1'b1;
    end
    last_pos = pos;
    e++;
    @(negedge clk);
    in_valid = 1'b0;
    chk("scan", {19'd0, an, seg, dp, frame_tick}, {19'd0, ea, es, edp, eft});
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 4'h0);
  endtask

  task automatic to_boundary(input string name);
    int guard;
    guard = 0;
    while (last_pos != FRAME - 1 && guard < FRAME + 2) begin
      idle();
      guard++;
    end
    chk({name, "_sync"}, {31'd0, last_pos == FRAME - 1}, 32'd1);
  endtask

  task automatic frame_check(input string name, input logic [27:0] segs,
                             input logic [3:0] lit, input logic [3:0] dpo);
    int d;
    to_boundary(name);
    for (int i = 0; i < FRAME; i++) begin
      idle();
      if (last_pos % P == P - 1) begin
        d = 3 - last_pos / P;
        if (lit[d]) chk(name, {20'd0, an, seg, dp}, {20'd0, ~(4'b0001 << d), segs[d*7 +: 7], dpo[d]});
        else        chk(name, {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
      end
    end
  endtask

  task automatic apply_vec(input int i);
    int guard;
    guard = 0;
    if (vecs[i].on_bnd) begin
      while (e % FRAME != FRAME - 1 && guard < FRAME + 2) begin
        idle();
        guard++;
      end
    end else if (e % FRAME == FRAME - 1) begin
      idle();
    end
    step(1'b1, vecs[i].val, vecs[i].dpi);
    $display("vector %0d: value %h dp_in %b boundary=%0d", i, vecs[i].val, vecs[i].dpi, vecs[i].on_bnd);
    frame_check($sformatf("vec%0d", i), vecs[i].segs, vecs[i].lit, vecs[i].dpo);
  endtask

  task automatic post_release(input string name);
    idle();
    chk({name, "_blank1"}, {28'd0, an}, 32'hF);
    idle();
    chk({name, "_blank2"}, {28'd0, an}, 32'hF);
    idle();
    chk({name, "_thousands_on"}, {28'd0, an}, LZB ? 32'hF : 32'h7);
  endtask

  initial begin : main
    int guard;
    int nval;
    logic [15:0] rv;
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    vecs[0] = '{16'h1234, 4'b0010, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, 4'b1101};
    vecs[1] = '{16'h5555, 4'b0000, 1'b1, {4{7'b0010010}}, 4'hF, 4'hF};
    vecs[2] = '{16'hC000, 4'b1000, 1'b0,
                {7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000}, 4'hF, 4'b0111};
    vecs[3] = '{16'h0007, 4'b0000, 1'b1,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, LZB ? 4'b0001 : 4'hF, 4'hF};
    vecs[4] = '{16'h0000, 4'b0001, 1'b0, {4{7'b1000000}}, LZB ? 4'b0001 : 4'hF, 4'b1110};
    vecs[5] = '{16'h0100, 4'b0110, 1'b0,
                {7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000}, LZB ? 4'b0111 : 4'hF, 4'b1001};
    vecs[6] = '{16'hABEF, 4'b1111, 1'b1, {4{7'b0111111}}, 4'hF, 4'b0000};
    vecs[7] = '{16'h9876, 4'b0000, 1'b0,
                {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}, 4'hF, 4'hF};

    in_valid = 1'b0; thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0; dp_in = 4'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_seg", {25'd0, seg}, 32'h7F);
    chk("reset_dp", {31'd0, dp}, 32'd1);
    chk("reset_tick", {31'd0, frame_tick}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    post_release("release");

    apply_vec(0);

    // Update strobed during the hundreds slot must not disturb the rest of the frame.
    guard = 0;
    while (e % FRAME != P + 3 && guard < FRAME + 2) begin
      idle();
      guard++;
    end
    step(1'b1, 16'h9876, 4'h0);
    $display("mid-frame update: value 9876 during hundreds slot");
    guard = 0;
    do begin
      idle();
      if (last_pos == 3 * P - 1) chk("mid_keep_tens", {25'd0, seg}, {25'd0, 7'b0110000});
      if (last_pos == FRAME - 1) chk("mid_keep_ones", {25'd0, seg}, {25'd0, 7'b0011001});
      guard++;
    end while (last_pos != FRAME - 1 && guard < FRAME + 2);
    for (int i = 0; i < P; i++) begin
      idle();
      if (last_pos == P - 1) chk("mid_next_thousands", {25'd0, seg}, {25'd0, 7'b0010000});
    end

    // Asynchronous reset while the hundreds digit is lit.
    guard = 0;
    while (last_pos != P + B + 1 && guard < FRAME + 2) begin
      idle();
      guard++;
    end
    chk("pre_reset_hundreds_lit", {28'd0, an}, 32'hB);
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-scan");
    chk("midreset_an", {28'd0, an}, 32'hF);
    chk("midreset_seg", {25'd0, seg}, 32'h7F);
    chk("midreset_dp", {31'd0, dp}, 32'd1);
    chk("midreset_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    post_release("rerelease");

    for (int i = 0; i < NV; i++) apply_vec(i);

    // Two strobes in one frame: only the later one reaches the display.
    to_boundary("lastwins");
    repeat (5) idle();
    step(1'b1, 16'h1111, 4'h0);
    repeat (3) idle();
    step(1'b1, 16'h2222, 4'b0100);
    $display("two strobes in one frame: 1111 then 2222");
    frame_check("last_wins", {4{7'b0100100}}, 4'hF, 4'b1011);

    nval = 0;
    for (int i = 0; i < 1500; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv[15:8] = 8'h00;
      if ($urandom_range(0, 15) == 0) begin
        step(1'b1, rv, 4'($urandom));
        nval++;
      end else begin
        idle();
      end
    end
    $display("random phase: %0d strobes over 1500 cycles", nval);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
